// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the iterative MAC datapath.
// Latency: n/a (package). Backpressure: n/a.
// Saturation option is selected in mac_iter by MAC_ITER_SAT_EN.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PP_W = 8;

  // Bits needed for the partial-product step counter (N*N steps), never below 1.
  function automatic int step_w(input int width);
    int nn;
    nn = (width / PP_W) * (width / PP_W);
    return (nn <= 1) ? 1 : $clog2(nn);
  endfunction

endpackage

// File: rtl/mac_iter_pp_mul8.sv
// Combinational 8x8 unsigned partial-product multiplier.
// Latency: 0 cycles. Backpressure: none (pure combinational).
module pp_mul8
  import mac_pkg::*;
(
  input  logic [PP_W-1:0]   a,
  input  logic [PP_W-1:0]   b,
  output logic [2*PP_W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mac_iter.sv
// Iterative unsigned WIDTHxWIDTH multiply-accumulate using one 8x8 multiplier; MAC_ITER_SAT_EN enables saturation.
// Latency: out_valid after N*N+1 edges from the accepting edge; one op per N*N+3 cycles.
// Backpressure: in_ready only in IDLE; result and out_valid hold while out_ready=0.
module mac_iter
  import mac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [ACC_W-1:0]   out_acc,
  output logic               ovf
);

  localparam int N  = WIDTH / PP_W;
  localparam int NN = N * N;
  localparam int KW = step_w(WIDTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_MUL  = 2'(MUL);
  localparam logic [1:0] S_ACC  = 2'(ACC);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]               state;
  logic [KW-1:0]            k;
  logic [WIDTH-1:0]         a_q, b_q;
  logic                     clr_q;
  logic [2*WIDTH-1:0]       prod;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_base;
  logic [ACC_W-1:0]         acc_nxt;

  logic [N-1:0][PP_W-1:0]   a_bytes, b_bytes;
  logic [IW-1:0]            ii, jj;
  logic [2*PP_W-1:0]        pp;
  logic [2*WIDTH-1:0]       pp_ext;

  assign in_ready = (state == S_IDLE);

  // Byte mux: step k walks a's bytes in the outer loop and b's in the inner loop.
  assign a_bytes = a_q;
  assign b_bytes = b_q;
  assign ii      = IW'(k / KW'(N));
  assign jj      = IW'(k % KW'(N));

  pp_mul8 u_pp (
    .a (a_bytes[ii]),
    .b (b_bytes[jj]),
    .p (pp)
  );

  assign pp_ext   = (2*WIDTH)'(pp) << (PP_W * (int'(ii) + int'(jj)));
  assign acc_base = clr_q ? '0 : acc;

`ifdef MAC_ITER_SAT_EN
  logic [ACC_W:0] sum;
  logic           ovf_q;
  logic           ovf_nxt;

  assign sum     = {1'b0, acc_base} + (ACC_W+1)'(prod);
  assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  // A clearing op drops saturation history unless it saturates itself.
  assign ovf_nxt = sum[ACC_W] | (~clr_q & ovf_q);
  assign ovf     = ovf_q;

  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (state == S_ACC)
      ovf_q <= ovf_nxt;
  end
`else
  assign acc_nxt = acc_base + ACC_W'(prod);
  assign ovf     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      clr_q     <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            clr_q <= in_clr;
            prod  <= '0;
            k     <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod <= prod + pp_ext;
          k    <= k + 1'b1;
          if (k == KW'(NN - 1))
            state <= S_ACC;
        end
        S_ACC: begin
          acc       <= acc_nxt;
          out_acc   <= acc_nxt;
          out_prod  <= prod;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_iter.sv
// Directed bench for mac_iter: three instances (16/40, 16/32, 32/64) share clock, reset and operands.
// Expected values are hand-computed; overflow expectations follow MAC_ITER_SAT_EN.
module tb_mac_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        clr_in = 1'b0;
  logic        out_rdy = 1'b0;
  logic        vld [3];
  logic        rdy [3];
  logic        ov  [3];
  logic        ovf [3];
  logic [63:0] po  [3];
  logic [63:0] ao  [3];

  logic [31:0] p0, p1;
  logic [63:0] p2;
  logic [39:0] acc0;
  logic [31:0] acc1;
  logic [63:0] acc2;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  initial begin
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    vld[2] = 1'b0;
  end

  mac_iter #(.WIDTH(16), .ACC_W(40)) u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_a(a_in[15:0]), .in_b(b_in[15:0]), .in_clr(clr_in),
    .out_valid(ov[0]), .out_ready(out_rdy), .out_prod(p0), .out_acc(acc0), .ovf(ovf[0])
  );

  mac_iter #(.WIDTH(16), .ACC_W(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_a(a_in[15:0]), .in_b(b_in[15:0]), .in_clr(clr_in),
    .out_valid(ov[1]), .out_ready(out_rdy), .out_prod(p1), .out_acc(acc1), .ovf(ovf[1])
  );

  mac_iter #(.WIDTH(32), .ACC_W(64)) u2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_a(a_in), .in_b(b_in), .in_clr(clr_in),
    .out_valid(ov[2]), .out_ready(out_rdy), .out_prod(p2), .out_acc(acc2), .ovf(ovf[2])
  );

  assign po[0] = 64'(p0);
  assign po[1] = 64'(p1);
  assign po[2] = p2;
  assign ao[0] = 64'(acc0);
  assign ao[1] = 64'(acc1);
  assign ao[2] = acc2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on instance s and wait (bounded) for out_valid; lat = edges after acceptance.
  task automatic op(input int s, input logic [31:0] a, input logic [31:0] b, input logic c,
                    output int l);
    chk("ready_before_op", {63'd0, rdy[s]}, 64'd1);
    a_in   = a;
    b_in   = b;
    clr_in = c;
    vld[s] = 1'b1;
    @(posedge clk); #1;
    vld[s] = 1'b0;
    l = 0;
    while (ov[s] !== 1'b1 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic consume(input int s);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk("ready_after_consume", {63'd0, rdy[s]}, 64'd1);
    chk("valid_after_consume", {63'd0, ov[s]}, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", {63'd0, ov[0]},  64'd0);
    chk("rst_out_prod",  po[0],           64'd0);
    chk("rst_out_acc",   ao[0],           64'd0);
    chk("rst_ovf",       {63'd0, ovf[0]}, 64'd0);
    chk("rst_in_ready",  {63'd0, rdy[0]}, 64'd1);

    op(0, 32'hFFFF, 32'hFFFF, 1'b1, lat);
    chk("w16_latency", 64'(lat), 64'd5);
    chk("w16_max_prod", po[0], 64'hFFFE0001);
    chk("w16_max_acc",  ao[0], 64'h00FFFE0001);
    chk("w16_busy_ready", {63'd0, rdy[0]}, 64'd0);
    consume(0);
    chk("prod_held_idle", po[0], 64'hFFFE0001);

    op(0, 32'h1234, 32'h5678, 1'b1, lat);
    chk("mixed_prod", po[0], 64'h06260060);
    chk("mixed_acc",  ao[0], 64'h06260060);
    consume(0);

    op(0, 32'd3, 32'd5, 1'b1, lat);
    chk("acc_first", ao[0], 64'hF);
    consume(0);
    op(0, 32'h100, 32'h100, 1'b0, lat);
    chk("acc_second_prod", po[0], 64'h10000);
    chk("acc_second_acc",  ao[0], 64'h1000F);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, ov[0]},  64'd1);
      chk("bp_ready", {63'd0, rdy[0]}, 64'd0);
      chk("bp_acc",   ao[0],           64'h1000F);
      chk("bp_prod",  po[0],           64'h10000);
    end
    consume(0);

    // Reset while k=2 in MUL.
    a_in = 32'd5; b_in = 32'd6; clr_in = 1'b0; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", {63'd0, ov[0]},  64'd0);
    chk("midrst_acc",   ao[0],           64'd0);
    chk("midrst_prod",  po[0],           64'd0);
    chk("midrst_ready", {63'd0, rdy[0]}, 64'd1);
    op(0, 32'd2, 32'd7, 1'b0, lat);
    chk("post_rst_acc", ao[0], 64'd14);
    consume(0);

    op(1, 32'hFFFF, 32'hFFFF, 1'b1, lat);
    chk("ovf_first_acc", ao[1], 64'hFFFE0001);
    chk("ovf_first_flag", {63'd0, ovf[1]}, 64'd0);
    consume(1);
    op(1, 32'hFFFF, 32'hFFFF, 1'b0, lat);
`ifdef MAC_ITER_SAT_EN
    chk("ovf_second_acc", ao[1], 64'hFFFFFFFF);
    chk("ovf_second_flag", {63'd0, ovf[1]}, 64'd1);
`else
    chk("ovf_second_acc", ao[1], 64'hFFFC0002);
    chk("ovf_second_flag", {63'd0, ovf[1]}, 64'd0);
`endif
    consume(1);
    op(1, 32'd1, 32'd1, 1'b0, lat);
`ifdef MAC_ITER_SAT_EN
    chk("ovf_sticky_acc", ao[1], 64'hFFFFFFFF);
    chk("ovf_sticky_flag", {63'd0, ovf[1]}, 64'd1);
`else
    chk("ovf_sticky_acc", ao[1], 64'hFFFC0003);
    chk("ovf_sticky_flag", {63'd0, ovf[1]}, 64'd0);
`endif
    consume(1);
    op(1, 32'd1, 32'd1, 1'b1, lat);
    chk("ovf_clear_acc", ao[1], 64'd1);
    chk("ovf_clear_flag", {63'd0, ovf[1]}, 64'd0);
    consume(1);

    op(2, 32'h12345678, 32'h00000001, 1'b1, lat);
    chk("w32_latency", 64'(lat), 64'd17);
    chk("w32_prod", po[2], 64'h12345678);
    chk("w32_acc",  ao[2], 64'h12345678);
    consume(2);
    op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
    chk("w32_max_prod", po[2], 64'hFFFFFFFE00000001);
    chk("w32_max_acc",  ao[2], 64'hFFFFFFFE00000001);
    consume(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_iter.md
# mac_iter

Parametrised, iterative multiply-accumulate unit for the MAC datapath. It computes an unsigned WIDTH×WIDTH product by time-multiplexing a single 8×8 partial-product multiplier over (WIDTH/8)² cycles, then adds the product into a wide accumulator. Input and output use valid/ready handshakes. It trades the area of the parallel four-multiplier 16-bit design for latency, and scales to 64-bit operands.

## Interface
- WIDTH, 16, operand width in bits; multiple of 8, range 8..64; N = WIDTH/8
- ACC_W, 40, accumulator width; must be ≥ 2*WIDTH
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- in_a  in  WIDTH  multiplicand, unsigned
- in_b  in  WIDTH  multiplier, unsigned
- in_clr  in  1  sampled with the operands; 1 = replace the accumulator instead of adding to it
- out_valid  out  1  result available
- out_ready  in  1  result consumed
- out_prod  out  2*WIDTH  product of the last operation
- out_acc  out  ACC_W  accumulator after the last operation
- ovf  out  1  sticky saturation flag (see Configuration)

## Operation
- States are IDLE, MUL, ACC and DONE.
- **IDLE:** in_ready=1. On in_valid && in_ready:
  - latch in_a, in_b and in_clr;
  - clear the product register and the step counter k;
  - go to MUL.
- **MUL:** runs for N² cycles, k = 0..N²-1, with i = k / N and j = k mod N.
  - Each cycle: prod += (a[8i+7:8i] × b[8j+7:8j]) << 8(i+j).
  - Exit to ACC when k = N²-1.
- **ACC:** runs for one cycle.
  - acc ← (clr ? 0 : acc) + zero-extended prod, modulo 2^ACC_W.
  - Go to DONE.
- **DONE:** out_valid=1, and out_prod and out_acc are stable. On out_ready, go to IDLE.
- All arithmetic is unsigned. The product register is 2*WIDTH bits and never overflows.
- Outputs are registered. out_prod and out_acc keep their last values after the return to IDLE.
- Reset values are all zero:
  - outputs: out_valid, out_prod, out_acc, ovf;
  - internal state: state=IDLE, k=0, prod=0, acc=0.
  - in_ready is 1 in the first cycle after reset.

## Timing
- **Accept:** the accepting edge is E0.
- **Latency:** out_valid is first visible after edge E0+N²+1; for WIDTH=16 that is edge 5.
- **Throughput:** without backpressure, one operation per N²+3 cycles. in_ready returns 1 in the cycle after the out_valid && out_ready edge.
- **No overlap:** in_ready=0 in MUL, ACC and DONE. in_valid is ignored there, so a new request can never collide with one in progress.
- **Backpressure:** out_valid and the output data hold indefinitely while out_ready=0.
- **Reset mid-operation:** rst in any state has effect at the next edge:
  - state goes to IDLE;
  - the current operation is dropped;
  - acc, prod, ovf and all outputs are cleared.
- A request with in_clr=1 discards the accumulator history, including any saturation.

## Configuration
- Macro: MAC_ITER_SAT_EN.
- **Defined:**
  - If the ACC-state sum exceeds 2^ACC_W−1, acc clamps to 2^ACC_W−1 and ovf sets.
  - ovf is sticky; it clears only on rst or on an operation with in_clr=1 that does not itself saturate.
- **Undefined:**
  - The sum wraps modulo 2^ACC_W.
  - ovf is tied to 0.
  - No comparator logic is synthesised.

## Structure
- Package mac_pkg holds:
  - the state enum typedef (IDLE, MUL, ACC, DONE);
  - constant PP_W=8;
  - a function computing the step-counter width from WIDTH, i.e. clog2(N²) with a minimum of 1.
- One sub-module, pp_mul8: combinational 8×8 unsigned multiplier with a 16-bit product.
  - It is the only multiplier instance.
  - A byte mux in front of it selects a[i] and b[j] from k.
- The top level holds the FSM, counter, shifter and adders, plus the saturation compare under the macro.

## Test plan
- WIDTH=16, ACC_W=40:
  - a=0xFFFF, b=0xFFFF, clr=1 → out_prod=0xFFFE0001, out_acc=0x00FFFE0001;
  - out_valid first high after edge 5 from acceptance.
- Accumulation:
  - clr=1, a=3, b=5 → acc=0xF;
  - then clr=0, a=0x100, b=0x100 → out_prod=0x10000, out_acc=0x1000F.
- Backpressure:
  - hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, in_ready stays 0, data unchanged;
  - raise out_ready → in_ready=1 in the next cycle.
- Reset mid-MUL:
  - assert rst when k=2 → after the edge: state IDLE, out_valid=0, out_acc=0, in_ready=1;
  - a following operation a=2, b=7, clr=0 → out_acc=14.
- Overflow, WIDTH=16, ACC_W=32, a=b=0xFFFF:
  - first with clr=1, then with clr=0;
  - without MAC_ITER_SAT_EN → out_acc=0xFFFC0002, ovf=0;
  - with MAC_ITER_SAT_EN → out_acc=0xFFFFFFFF, ovf=1, ovf still 1 after a further clr=0 operation a=1, b=1.
- WIDTH=32:
  - a=0x12345678, b=0x00000001, clr=1 → out_prod=0x12345678;
  - out_valid first high after edge 17 from acceptance.
